// File: rtl/dmem_sync.sv
//==============================================================================
// Module      : dmem_sync
// Description : Single-port word-addressed data memory with byte-lane writes,
//               one-cycle read latency and a sequenced full-memory clear.
//               Optional macro DMEM_SYNC_BOUNDS_CHECK_EN enables out-of-range
//               access suppression and the err pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic              clear,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              oob;
    logic [IDX_W-1:0]  word_idx;
    logic              unused_addr_bits;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs (forced to their reset values while reset is held)
    //--------------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        if (!reset && state_q == ST_IDLE) begin
            req_ready = 1'b1;
            busy      = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------------
    assign accept           = req_valid && req_ready;
    assign word_idx         = req_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};

`ifdef DMEM_SYNC_BOUNDS_CHECK_EN
    logic err_q;

    assign oob = |req_addr[ADDR_W-1:IDX_W+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && oob;
        end
    end

    assign err = err_q;
`else
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    // Memory itself is not reset; the post-reset CLEAR sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_q[idx_q] <= '0;
            end else if (accept && req_we && !oob) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be[b]) begin
                        mem_q[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = accept && !req_we;
        rdata_d     = rdata_q;
        if (rsp_valid_d) begin
            rdata_d = oob ? '0 : mem_q[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_sync.sv
//==============================================================================
// Module      : tb_dmem_sync
// Description : Directed self-checking bench for dmem_sync (DEPTH=64, 32-bit).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_sync;

`ifdef DMEM_SYNC_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        clear;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_sync #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .clear     (clear),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive busy cycles from now, bounded at 200.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        reset = 1'b0;
        count_busy(n);
        n_checks++; if (n != 64) begin n_fail++; $display("FAIL reset_clear_len: got %0d expected 64", n); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", req_ready); end
        do_read(32'h0);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rd0_after_clear: got v=%b d=%h expected v=1 d=0", rsp_valid, rsp_rdata); end
        do_read(32'h4);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rd4_after_clear: got v=%b d=%h expected v=1 d=0", rsp_valid, rsp_rdata); end
        do_read(32'hFC);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rdFC_after_clear: got v=%b d=%h expected v=1 d=0", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_write_read();
        do_write(32'h4, 32'h0000007B, 4'hF);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_no_rsp: got %b expected 0", rsp_valid); end
        do_read(32'h4);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000007B) begin n_fail++; $display("FAIL rd4: got v=%b d=%h expected v=1 d=0000007b", rsp_valid, rsp_rdata); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0000007B) begin n_fail++; $display("FAIL rsp_hold: got v=%b d=%h expected v=0 d=0000007b", rsp_valid, rsp_rdata); end
        do_read(32'h6);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000007B) begin n_fail++; $display("FAIL rd6_unaligned: got v=%b d=%h expected v=1 d=0000007b", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_byte_enable();
        do_write(32'h8, 32'hAABBCCDD, 4'hF);
        do_write(32'h8, 32'h11223344, 4'h5);
        do_read(32'h8);
        n_checks++; if (rsp_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_merge: got %h expected aa22cc44", rsp_rdata); end
        do_write(32'h8, 32'hFFFFFFFF, 4'h0);
        do_read(32'h8);
        n_checks++; if (rsp_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_zero: got %h expected aa22cc44", rsp_rdata); end
        do_write(32'h8, 32'h00990000, 4'h4);
        do_read(32'h8);
        n_checks++; if (rsp_rdata !== 32'hAA99CC44) begin n_fail++; $display("FAIL be_lane2: got %h expected aa99cc44", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        do_write(32'h20, 32'h01010101, 4'hF);
        do_write(32'h24, 32'h02020202, 4'hF);
        do_write(32'h28, 32'h03030303, 4'hF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h01010101) begin n_fail++; $display("FAIL b2b_0: got v=%b d=%h expected v=1 d=01010101", rsp_valid, rsp_rdata); end
        req_addr = 32'h24;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h02020202) begin n_fail++; $display("FAIL b2b_1: got v=%b d=%h expected v=1 d=02020202", rsp_valid, rsp_rdata); end
        req_addr = 32'h28;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h03030303) begin n_fail++; $display("FAIL b2b_2: got v=%b d=%h expected v=1 d=03030303", rsp_valid, rsp_rdata); end
        req_valid = 1'b0;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_clear();
        int n;
        do_write(32'h10, 32'h00000050, 4'hF);
        clear = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        tick();
        clear = 1'b0; req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000050) begin n_fail++; $display("FAIL clear_same_cycle_rd: got v=%b d=%h expected v=1 d=00000050", rsp_valid, rsp_rdata); end
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL clear_entry: got busy=%b ready=%b expected busy=1 ready=0", busy, req_ready); end
        // A clear pulse arriving mid-sequence must not extend it.
        for (int i = 0; i < 10; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        count_busy(n);
        n_checks++; if (n + 11 != 64) begin n_fail++; $display("FAIL clear_len: got %0d expected 64", n + 11); end
        do_read(32'h10);
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL clear_rd10: got %h expected 0", rsp_rdata); end
        do_read(32'h8);
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL clear_rd8: got %h expected 0", rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_write(32'h30, 32'h12345678, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL midclear_reset: got busy=%b ready=%b expected busy=1 ready=0", busy, req_ready); end
        reset = 1'b0;
        count_busy(n);
        n_checks++; if (n != 64) begin n_fail++; $display("FAIL midclear_restart_len: got %0d expected 64", n); end
        do_write(32'h30, 32'hCAFEF00D, 4'hF);
        do_read(32'h30);
        n_checks++; if (rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pre_abort_rd: got %h expected cafef00d", rsp_rdata); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; reset = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL access_abort: got v=%b d=%h expected v=0 d=0", rsp_valid, rsp_rdata); end
        reset = 1'b0;
        count_busy(n);
        n_checks++; if (n != 64) begin n_fail++; $display("FAIL abort_restart_len: got %0d expected 64", n); end
    endtask

    task automatic test_bounds();
        do_write(32'h100, 32'h00000001, 4'hF);
        n_checks++; if (err !== BC) begin n_fail++; $display("FAIL oob_wr_err: got %b expected %b", err, BC); end
        do_read(32'h100);
        n_checks++; if (err !== BC) begin n_fail++; $display("FAIL oob_rd_err: got %b expected %b", err, BC); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== (BC ? 32'h0 : 32'h1)) begin n_fail++; $display("FAIL oob_rd_data: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_rdata, (BC ? 32'h0 : 32'h1)); end
        do_read(32'h0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL inrange_err: got %b expected 0", err); end
        n_checks++; if (rsp_rdata !== (BC ? 32'h0 : 32'h1)) begin n_fail++; $display("FAIL word0_after_oob: got %h expected %h", rsp_rdata, (BC ? 32'h0 : 32'h1)); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; clear = 1'b0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_sync.md
DMEM_SYNC -- requirements
Module: dmem_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: data word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 64: number of words, a power of two.
REQ-003 The block SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-004 The block SHALL have clk  input  1: clock; all state updates on its rising edge.
REQ-005 The block SHALL have reset  input  1: reset, synchronous, active-high.
REQ-006 The block SHALL have req_valid  input  1: access request present.
REQ-007 The block SHALL have req_ready  output  1: the request is accepted in this cycle.
REQ-008 The block SHALL have req_we  input  1: 1 = write, 0 = read.
REQ-009 The block SHALL have req_addr  input  ADDR_W: byte address of the access.
REQ-010 The block SHALL have req_wdata  input  DATA_W: write data.
REQ-011 The block SHALL have req_be  input  DATA_W/8: byte-lane write enables.
REQ-012 The block SHALL have clear  input  1: one-cycle pulse requesting a full-memory clear.
REQ-013 The block SHALL have rsp_valid  output  1: read data valid.
REQ-014 The block SHALL have rsp_rdata  output  DATA_W: read data.
REQ-015 The block SHALL have busy  output  1: clear sequence in progress.
REQ-016 The block SHALL have err  output  1: out-of-range access flag.

Function
REQ-017 The state machine SHALL have two states:
- CLEAR: writes zero to one word per cycle, index 0 to DEPTH-1.
- IDLE: serves requests.
REQ-018 CLEAR SHALL last exactly DEPTH cycles, then go to IDLE; busy=1 and req_ready=0 throughout CLEAR.
REQ-019 In IDLE, req_ready SHALL be 1 and busy SHALL be 0; an access is accepted when req_valid && req_ready.
REQ-020 A clear pulse sampled in IDLE SHALL move the FSM to CLEAR on the next cycle, index restarting at 0.
- A request in the same cycle as clear SHALL still be accepted and completed.
- clear SHALL be ignored while in CLEAR.
REQ-021 Word index SHALL be req_addr[log2(DEPTH)+1:2]; req_addr[1:0] SHALL be ignored (word aligned).
REQ-022 An accepted write SHALL update only the byte lanes whose req_be bit is 1; other lanes SHALL keep their value.
- A write with req_be=0 SHALL leave memory unchanged.
REQ-023 An accepted read SHALL assert rsp_valid for exactly one cycle, in the cycle after acceptance, with rsp_rdata equal to the stored word.
REQ-024 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-025 A read accepted the cycle after a write to the same word SHALL return the newly written bytes.
REQ-026 Writes SHALL produce no response (rsp_valid stays 0).
REQ-027 Back-to-back accepted reads SHALL give one rsp_valid per cycle, in request order.

Reset
REQ-028 While reset=1, the block SHALL hold these output values:
- rsp_valid=0, rsp_rdata=0, err=0, req_ready=0, busy=1.
- The clear index SHALL be held at 0.
REQ-029 In the first cycle after reset deasserts, the FSM SHALL be in CLEAR; memory SHALL be all-zero after DEPTH further cycles.
REQ-030 A reset asserted mid-CLEAR or mid-access SHALL abort the operation, drop any pending response, and restart CLEAR from index 0.

Configuration
REQ-031 With macro DMEM_SYNC_BOUNDS_CHECK_EN defined, an accepted access with req_addr >= DEPTH*4 SHALL follow these rules:
- A write SHALL be suppressed.
- A read SHALL return rsp_rdata=0.
- err SHALL pulse for one cycle, in the cycle after acceptance.
REQ-032 With DMEM_SYNC_BOUNDS_CHECK_EN undefined, the address SHALL wrap modulo DEPTH words and err SHALL be tied 0.

Verification
REQ-033 Reset for 2 cycles, then release -> busy=1 for 64 cycles, then req_ready=1; reads of 0x0, 0x4, 0xFC return 0.
REQ-034 Write 0x0000007B to 0x4 with be=0xF, then read 0x4 -> rsp_valid the next cycle with rdata=0x0000007B; read 0x6 -> 0x0000007B.
REQ-035 Write 0xAABBCCDD to 0x8 (be=0xF), then write 0x11223344 with be=0x5, then read 0x8 -> 0xAA22CC44.
REQ-036 Write 0x50 to 0x10, pulse clear with a read of 0x10 in the same cycle:
- The read returns 0x50.
- busy=1 for 64 cycles.
- A read of 0x10 afterwards returns 0.
REQ-037 Reset asserted at clear index 30, then released -> CLEAR restarts and busy stays 1 for a full 64 cycles.
REQ-038 Out-of-range access with the macro defined versus undefined:
- Defined: write 0x1 to 0x100, then read 0x100 -> err pulses, rdata=0, word 0 unchanged.
- Undefined: the same sequence gives err=0 and the read of 0x0 returns 0x1.
